// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - BTB plus PHT branch predictor (static, bimodal or gshare)
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int CTR_W   = 2,
    parameter int MODE    = 1,
    parameter int GHR_W   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            lkpValid,
    input  logic [XLEN-1:0] lkpPc,
    output logic            predHit,
    output logic            predTaken,
    output logic [XLEN-1:0] predTarget,
    input  logic            updValid,
    input  logic [XLEN-1:0] updPc,
    input  logic            updTaken,
    input  logic [XLEN-1:0] updTarget,
    input  logic            updJmp,
    input  logic            flush
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam bit LEARN  = (MODE != 0);
    localparam bit GSHARE = (MODE == 2);
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));
    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [XLEN-1:0]  r_target [ENTRIES];
    logic             r_jmp    [ENTRIES];
    logic [CTR_W-1:0] r_pht    [ENTRIES];
    logic [GHR_W-1:0] r_ghr;

    logic [IDX_W-1:0] w_ghr_ext;
    logic [IDX_W-1:0] w_lkp_idx;
    logic [IDX_W-1:0] w_lkp_pidx;
    logic [TAG_W-1:0] w_lkp_tag;
    logic             w_lkp_hit;
    logic             w_lkp_taken;
    logic [IDX_W-1:0] w_upd_idx;
    logic [IDX_W-1:0] w_upd_pidx;
    logic [TAG_W-1:0] w_upd_tag;
    logic             w_upd_hit;
    logic             w_upd_cond;
    logic             w_btb_wr;
    logic             w_alloc;
    logic [CTR_W-1:0] w_upd_ctr;
    logic [CTR_W-1:0] w_pht_next;
    logic             w_unused_upd;

    always_comb begin
        w_ghr_ext = '0;
        w_ghr_ext[GHR_W-1:0] = r_ghr;
    end

    assign w_lkp_idx   = lkpPc[IDX_W+1:2];
    assign w_lkp_tag   = lkpPc[IDX_W+2+TAG_W-1:IDX_W+2];
    assign w_lkp_pidx  = GSHARE ? (w_lkp_idx ^ w_ghr_ext) : w_lkp_idx;
    assign w_lkp_hit   = LEARN && lkpValid && r_valid[w_lkp_idx] && (r_tag[w_lkp_idx] == w_lkp_tag);
    assign w_lkp_taken = w_lkp_hit && (r_jmp[w_lkp_idx] || r_pht[w_lkp_pidx][CTR_W-1]);

    assign predHit    = w_lkp_hit;
    assign predTaken  = w_lkp_taken;
    assign predTarget = w_lkp_taken ? r_target[w_lkp_idx] : lkpPc + XLEN'(4);

    // Update side indexes with the pre-shift GHR, matching the history the lookup saw.
    assign w_upd_idx    = updPc[IDX_W+1:2];
    assign w_upd_tag    = updPc[IDX_W+2+TAG_W-1:IDX_W+2];
    assign w_upd_pidx   = GSHARE ? (w_upd_idx ^ w_ghr_ext) : w_upd_idx;
    assign w_upd_hit    = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    assign w_upd_cond   = LEARN && updValid && !updJmp;
    assign w_btb_wr     = LEARN && updValid && updTaken && !flush;
    assign w_alloc      = updTaken && !w_upd_hit;
    assign w_upd_ctr    = r_pht[w_upd_pidx];
    assign w_unused_upd = ^updPc;

    always_comb begin
        w_pht_next = w_upd_ctr;
        if (w_alloc) begin
            w_pht_next = CTR_WT;
        end else if (updTaken) begin
            if (w_upd_ctr != CTR_MAX) w_pht_next = w_upd_ctr + CTR_W'(1);
        end else begin
            if (w_upd_ctr != '0) w_pht_next = w_upd_ctr - CTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_pht[i]   <= CTR_WNT;
            end
            r_ghr <= '0;
        end else begin
            if (LEARN && flush) begin
                for (int i = 0; i < ENTRIES; i++) r_valid[i] <= 1'b0;
            end else if (w_btb_wr) begin
                r_valid[w_upd_idx] <= 1'b1;
            end
            if (w_upd_cond) r_pht[w_upd_pidx] <= w_pht_next;
            if (GSHARE) begin
                if (flush) r_ghr <= '0;
                else if (w_upd_cond) r_ghr <= GHR_W'({r_ghr, updTaken});
            end
        end
    end

    // Payload arrays need no reset: they are only read behind a valid bit.
    always_ff @(posedge clk) begin
        if (w_btb_wr) begin
            r_tag[w_upd_idx]    <= w_upd_tag;
            r_target[w_upd_idx] <= updTarget;
            r_jmp[w_upd_idx]    <= updJmp;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed vector bench for branch_predictor
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lkpValid;
    logic [31:0] lkpPc;
    logic        updValid;
    logic [31:0] updPc;
    logic        updTaken;
    logic [31:0] updTarget;
    logic        updJmp;
    logic        flush;

    logic        hit1, tk1, hit2, tk2, hit0, tk0;
    logic [31:0] tg1, tg2, tg0;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    branch_predictor #(.MODE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .lkpValid(lkpValid), .lkpPc(lkpPc),
        .predHit(hit1), .predTaken(tk1), .predTarget(tg1),
        .updValid(updValid), .updPc(updPc), .updTaken(updTaken),
        .updTarget(updTarget), .updJmp(updJmp), .flush(flush)
    );

    branch_predictor #(.MODE(2), .GHR_W(4)) u_dut_gs (
        .clk(clk), .rst_n(rst_n), .lkpValid(lkpValid), .lkpPc(lkpPc),
        .predHit(hit2), .predTaken(tk2), .predTarget(tg2),
        .updValid(updValid), .updPc(updPc), .updTaken(updTaken),
        .updTarget(updTarget), .updJmp(updJmp), .flush(flush)
    );

    branch_predictor #(.MODE(0)) u_dut_st (
        .clk(clk), .rst_n(rst_n), .lkpValid(lkpValid), .lkpPc(lkpPc),
        .predHit(hit0), .predTaken(tk0), .predTarget(tg0),
        .updValid(updValid), .updPc(updPc), .updTaken(updTaken),
        .updTarget(updTarget), .updJmp(updJmp), .flush(flush)
    );

    typedef struct {
        bit          is_lkp;
        logic [31:0] pc;
        logic        tk;
        logic [31:0] tgt;
        logic        jmp;
        logic        lv;
        logic        e_hit;
        logic        e_tk;
        logic [31:0] e_tgt;
        string       name;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk_u(logic [31:0] pc, logic tk, logic [31:0] tgt, logic jmp);
        vec_t v;
        v.is_lkp = 1'b0; v.pc = pc; v.tk = tk; v.tgt = tgt; v.jmp = jmp;
        v.lv = 1'b0; v.e_hit = 1'b0; v.e_tk = 1'b0; v.e_tgt = '0; v.name = "";
        return v;
    endfunction

    function automatic vec_t mk_l(string name, logic [31:0] pc, logic lv, logic h, logic t, logic [31:0] g);
        vec_t v;
        v.is_lkp = 1'b1; v.pc = pc; v.tk = 1'b0; v.tgt = '0; v.jmp = 1'b0;
        v.lv = lv; v.e_hit = h; v.e_tk = t; v.e_tgt = g; v.name = name;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic look(input string name, input logic [31:0] pc, input logic lv,
                        input logic h, input logic t, input logic [31:0] g);
        lkpValid = lv;
        lkpPc    = pc;
        #1;
        chk({name, ".hit"}, {31'd0, hit1}, {31'd0, h});
        chk({name, ".taken"}, {31'd0, tk1}, {31'd0, t});
        chk({name, ".target"}, tg1, g);
        lkpValid = 1'b0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic jmp);
        updValid  = 1'b1;
        updPc     = pc;
        updTaken  = tk;
        updTarget = tgt;
        updJmp    = jmp;
        @(posedge clk);
        #1;
        updValid  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; lkpValid = 1'b0; lkpPc = '0; updValid = 1'b0; updPc = '0;
        updTaken = 1'b0; updTarget = '0; updJmp = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        look("reset_lkp", 32'h100, 1'b1, 1'b0, 1'b0, 32'h104);

        // Update and lookup in the same cycle must not bypass.
        updValid = 1'b1; updPc = 32'h100; updTaken = 1'b1; updTarget = 32'h40; updJmp = 1'b0;
        look("same_cycle", 32'h100, 1'b1, 1'b0, 1'b0, 32'h104);
        @(posedge clk);
        #1 updValid = 1'b0;

        tbl.push_back(mk_l("installed", 32'h100, 1'b1, 1'b1, 1'b1, 32'h40));
        tbl.push_back(mk_u(32'h100, 1'b0, 32'h40, 1'b0));
        tbl.push_back(mk_l("ctr1", 32'h100, 1'b1, 1'b1, 1'b0, 32'h104));
        tbl.push_back(mk_u(32'h100, 1'b0, 32'h40, 1'b0));
        tbl.push_back(mk_l("ctr0", 32'h100, 1'b1, 1'b1, 1'b0, 32'h104));
        tbl.push_back(mk_u(32'h100, 1'b1, 32'h40, 1'b0));
        tbl.push_back(mk_l("ctr0to1", 32'h100, 1'b1, 1'b1, 1'b0, 32'h104));
        tbl.push_back(mk_u(32'h100, 1'b1, 32'h40, 1'b0));
        tbl.push_back(mk_l("ctr2", 32'h100, 1'b1, 1'b1, 1'b1, 32'h40));
        tbl.push_back(mk_u(32'h100, 1'b1, 32'h40, 1'b0));
        tbl.push_back(mk_u(32'h100, 1'b1, 32'h40, 1'b0));
        tbl.push_back(mk_u(32'h100, 1'b0, 32'h40, 1'b0));
        tbl.push_back(mk_l("sat3_dec", 32'h100, 1'b1, 1'b1, 1'b1, 32'h40));
        tbl.push_back(mk_l("alias_tag", 32'h1100, 1'b1, 1'b0, 1'b0, 32'h1104));
        tbl.push_back(mk_u(32'h100, 1'b0, 32'h40, 1'b0));
        tbl.push_back(mk_u(32'h100, 1'b0, 32'h40, 1'b0));
        tbl.push_back(mk_u(32'h200, 1'b1, 32'h800, 1'b1));
        tbl.push_back(mk_l("jump", 32'h200, 1'b1, 1'b1, 1'b1, 32'h800));
        tbl.push_back(mk_l("evicted", 32'h100, 1'b1, 1'b0, 1'b0, 32'h104));
        tbl.push_back(mk_u(32'h104, 1'b1, 32'h500, 1'b0));
        tbl.push_back(mk_u(32'h104, 1'b1, 32'h500, 1'b0));
        tbl.push_back(mk_u(32'h104, 1'b0, 32'h999, 1'b0));
        tbl.push_back(mk_l("nt_keeps_tgt", 32'h104, 1'b1, 1'b1, 1'b1, 32'h500));
        tbl.push_back(mk_u(32'h108, 1'b0, 32'h700, 1'b0));
        tbl.push_back(mk_l("nt_no_alloc", 32'h108, 1'b1, 1'b0, 1'b0, 32'h10C));
        tbl.push_back(mk_u(32'h108, 1'b1, 32'h700, 1'b0));
        tbl.push_back(mk_l("alloc_wt", 32'h108, 1'b1, 1'b1, 1'b1, 32'h700));
        tbl.push_back(mk_l("lkp_invalid", 32'h104, 1'b0, 1'b0, 1'b0, 32'h108));
        tbl.push_back(mk_l("pc_wrap", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0));
        tbl.push_back(mk_u(32'h104, 1'b1, 32'h600, 1'b0));
        tbl.push_back(mk_l("hit_new_tgt", 32'h104, 1'b1, 1'b1, 1'b1, 32'h600));

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].is_lkp)
                look(tbl[i].name, tbl[i].pc, tbl[i].lv, tbl[i].e_hit, tbl[i].e_tk, tbl[i].e_tgt);
            else
                upd(tbl[i].pc, tbl[i].tk, tbl[i].tgt, tbl[i].jmp);
        end

        // Flush wins over a same-cycle allocation.
        flush = 1'b1;
        upd(32'h300, 1'b1, 32'h900, 1'b0);
        flush = 1'b0;
        look("flush_300", 32'h300, 1'b1, 1'b0, 1'b0, 32'h304);
        look("flush_104", 32'h104, 1'b1, 1'b0, 1'b0, 32'h108);
        look("flush_200", 32'h200, 1'b1, 1'b0, 1'b0, 32'h204);

        upd(32'h104, 1'b1, 32'h600, 1'b0);
        look("reinstall", 32'h104, 1'b1, 1'b1, 1'b1, 32'h600);
        lkpValid = 1'b1; lkpPc = 32'h104; #1;
        chk("static_hit", {31'd0, hit0}, 32'd0);
        chk("static_tgt", tg0, 32'h108);
        lkpValid = 1'b0;

        // Asynchronous reset mid-cycle clears learned state immediately.
        #2 rst_n = 1'b0;
        look("async_rst", 32'h104, 1'b1, 1'b0, 1'b0, 32'h108);
        @(posedge clk);
        #1 rst_n = 1'b1;
        upd(32'h108, 1'b1, 32'h700, 1'b0);
        look("post_rst_upd", 32'h108, 1'b1, 1'b1, 1'b1, 32'h700);
        look("post_rst_104", 32'h104, 1'b1, 1'b0, 1'b0, 32'h108);

        // Gshare: three taken updates move history to 0111, lookup index becomes 7.
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        upd(32'h100, 1'b1, 32'h40, 1'b0);
        upd(32'h100, 1'b1, 32'h40, 1'b0);
        upd(32'h100, 1'b1, 32'h40, 1'b0);
        lkpValid = 1'b1; lkpPc = 32'h100; #1;
        chk("gshare_hit", {31'd0, hit2}, 32'd1);
        chk("gshare_taken", {31'd0, tk2}, 32'd0);
        chk("gshare_tgt", tg2, 32'h104);
        chk("bimodal_taken", {31'd0, tk1}, 32'd1);
        chk("static_taken", {31'd0, tk0}, 32'd0);
        lkpValid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
